core_seq: RTL
=============

// Module: core_seq
// PURPOSE
//  Multi-cycle sequencer for the single-issue RV32 core. Steps each instruction through
//  FETCH/DECODE/EXEC/WB and emits the enables for PC update, IR capture and regfile write.
//  Sits between the top-level run control (system_active) and the pc/instr_mem/regfile datapath.
//  Halts permanently on an illegal-instruction error or a fetch timeout, and counts cycles and
//  retired instructions.
// PARAMETERS
//  CNT_W      32  width of the cycle and instret counters
//  TO_CYCLES  16  max cycles in FETCH waiting for mem_ready before a timeout halt (>=1)
// PORTS
//  clk            in   1      clock; all state changes on the rising edge
//  rst_i          in   1      synchronous, active-high reset
//  system_active  in   1      run enable; 0 parks the sequencer in IDLE
//  mem_ready      in   1      instr_mem data valid for the current fetch
//  error_i        in   1      illegal-instruction flag from the decode stage (sampled in DECODE)
//  step_i         in   1      single-step pulse; present only with CORE_SEQ_STEP_EN
//  fetch_req      out  1      high in FETCH: requests the instruction at the current PC
//  ir_load        out  1      1-cycle pulse: capture the instruction (FETCH and mem_ready)
//  rf_we_en       out  1      1-cycle pulse in WB: gates the decoder's we onto the regfile
//  pc_en          out  1      1-cycle pulse in WB: PC <= next_pc
//  halted         out  1      high in HALT
//  halt_cause     out  2      0 none, 1 illegal instruction, 2 fetch timeout
//  state          out  3      IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4 HALT=5
//  cycles         out  CNT_W  cycles spent outside IDLE and HALT
//  instret        out  CNT_W  instructions retired (count of WB cycles)
// BEHAVIOUR
//  Reset: state=IDLE; halt_cause=0; cycles=0; instret=0; timeout count=0. All pulse outputs and
//   halted are 0. Reset has priority over every other input, in any state, including mid-instruction.
//  All outputs are Moore outputs decoded from state (registered), except ir_load, which equals
//   FETCH && mem_ready.
//  IDLE:   if system_active then FETCH, else stay.
//  FETCH:  fetch_req=1.
//          - mem_ready=1: go to DECODE and clear the timeout count.
//          - otherwise increment the timeout count. When the count reaches TO_CYCLES-1 with mem_ready
//            still 0, go to HALT with halt_cause=2. With TO_CYCLES=16 this is the 16th consecutive
//            not-ready cycle.
//  DECODE: if error_i then HALT with halt_cause=1, else EXEC. error_i is ignored in every other state.
//  EXEC:   one cycle for the ALU result to settle, then WB.
//  WB:     pc_en=1, rf_we_en=1, instret++.
//          - system_active=1: go to FETCH.
//          - system_active=0: go to IDLE.
//  Mid-instruction deassert: system_active=0 in FETCH/DECODE/EXEC is ignored. The instruction
//   completes and the sequencer stops only at the WB boundary, so a partial retire never happens.
//  HALT:   sticky; halted=1; no pulses; counters frozen. Only rst_i leaves HALT.
//  Counters:
//   - cycles increments in FETCH/DECODE/EXEC/WB.
//   - Both counters wrap modulo 2^CNT_W silently; no saturation and no flag.
//  Latency: 4 cycles per instruction with mem_ready tied high (FETCH, DECODE, EXEC, WB).
//   PC advances on the clock edge that ends WB.
// CONFIGURATION
//  CORE_SEQ_STEP_EN defined:
//   - The step_i port exists.
//   - From WB the sequencer goes to IDLE regardless of system_active.
//   - It leaves IDLE only when system_active && step_i, which executes exactly one instruction.
//   - A step_i held high for N cycles still runs one instruction per IDLE visit.
//  CORE_SEQ_STEP_EN undefined:
//   - No step_i port.
//   - Free-running behaviour as specified above.
// TESTING
//  1 Reset, system_active=1, mem_ready=1, no error, 10 cycles -> state 0,1,2,3,4,1,...;
//    pc_en pulses at cycles 4 and 8; instret=2, cycles=9 after the 10th edge.
//  2 mem_ready low for 3 cycles in FETCH, then high -> 3 extra FETCH cycles; no halt;
//    ir_load only on the ready cycle.
//  3 mem_ready held 0, TO_CYCLES=16 -> HALT after 16 FETCH cycles; halt_cause=2; halted=1;
//    cycles frozen at 16.
//  4 error_i=1 in DECODE of the 2nd instruction -> HALT, halt_cause=1, instret=1;
//    rf_we_en and pc_en never pulse again.
//  5 system_active dropped during EXEC -> WB completes (instret+1), then IDLE; reassert -> FETCH next cycle.
//  6 rst_i pulsed in EXEC and again in HALT -> IDLE on the next edge, all counters 0, halt_cause 0.
//    With CORE_SEQ_STEP_EN: step_i pulsed 3 times -> instret=3, state returns to IDLE after each.

Source files
------------

// File: rtl/core_seq.sv
// core_seq: multi-cycle FETCH/DECODE/EXEC/WB sequencer with timeout/illegal halt and perf counters.
// Optional CORE_SEQ_STEP_EN adds step_i single-step control (one instruction per IDLE visit).
module core_seq #(
   parameter int CNT_W     = 32,
   parameter int TO_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             system_active,
   input  logic             mem_ready,
   input  logic             error_i,
`ifdef CORE_SEQ_STEP_EN
   input  logic             step_i,
`endif
   output logic             fetch_req,
   output logic             ir_load,
   output logic             rf_we_en,
   output logic             pc_en,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] cycles,
   output logic [CNT_W-1:0] instret
);
   localparam int TW = $clog2(TO_CYCLES) + 1;
   typedef enum logic [2:0] {IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, WB = 3'd4, HALT = 3'd5} st_t;
   st_t st;
   logic [TW-1:0] to_cnt;
   logic go;
   st_t wb_next;
`ifdef CORE_SEQ_STEP_EN
   assign go      = system_active && step_i;
   assign wb_next = IDLE;
`else
   assign go      = system_active;
   assign wb_next = system_active ? FETCH : IDLE;
`endif
   always_ff @(posedge clk) begin
      if (rst_i) begin
         st         <= IDLE;
         halt_cause <= 2'd0;
         cycles     <= '0;
         instret    <= '0;
         to_cnt     <= '0;
      end else begin
         if (st != IDLE && st != HALT) cycles <= cycles + CNT_W'(1);
         case (st)
            IDLE:   if (go) st <= FETCH;
            FETCH: begin
               if (mem_ready) begin
                  st     <= DECODE;
                  to_cnt <= '0;
               end else if (to_cnt == TW'(TO_CYCLES - 1)) begin
                  st         <= HALT;
                  halt_cause <= 2'd2;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            DECODE: begin
               st         <= error_i ? HALT : EXEC;
               halt_cause <= error_i ? 2'd1 : halt_cause;
            end
            EXEC:   st <= WB;
            WB: begin
               st      <= wb_next;
               instret <= instret + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end
   assign state     = st;
   assign fetch_req = st == FETCH;
   assign ir_load   = st == FETCH && mem_ready;
   assign pc_en     = st == WB;
   assign rf_we_en  = st == WB;
   assign halted    = st == HALT;
endmodule
